// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline-control encodings and constants
package riscv_pipe_pkg;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] X0 = '0;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_LU = 2'd1, ST_MC = 2'd2} state_t;
endpackage

// File: rtl/pipe_lu_detect.sv
// pipe_lu_detect: load-use hazard compare between EX load and ID sources
module pipe_lu_detect
  import riscv_pipe_pkg::*;
(
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              lu_hit
);
  assign lu_hit = ex_mem_read && ex_rd != X0 &&
                  ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline enable/flush sequencing for load-use, branch squash and multi-cycle EX
module pipe_stall_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_is_mc,
  input  logic              ex_br_taken,
  input  logic              mc_done,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              mc_start,
  output logic [CNT_W-1:0]  stall_cnt
);
  state_t     state;
  logic [1:0] lu_cnt;
  logic       lu_hit;
  pipe_lu_detect u_lu (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_mem_read(ex_mem_read),
    .lu_hit     (lu_hit)
  );
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mc_start    = 1'b0;
    if (rst) begin
      {pc_en, ifid_en, idex_en} = 3'b000;
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
    end else if (state == ST_MC) begin
      if (!mc_done) begin
        {pc_en, ifid_en, idex_en} = 3'b000;
        exmem_flush = 1'b1;
      end
    end else if (state == ST_LU) begin
      {pc_en, ifid_en} = 2'b00;
      idex_flush = 1'b1;
    end else if (state == ST_RUN) begin
      if (ex_br_taken) begin
        {ifid_flush, idex_flush} = 2'b11;
      end else if (ex_is_mc) begin
        {pc_en, ifid_en, idex_en} = 3'b000;
        exmem_flush = 1'b1;
        mc_start = 1'b1;
      end else if (lu_hit) begin
        {pc_en, ifid_en} = 2'b00;
        idex_flush = 1'b1;
      end
    end
  end
  // lu_cnt holds the bubbles still owed including the current LU cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      lu_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (!pc_en) stall_cnt <= stall_cnt + 1'b1;
      case (state)
        ST_RUN: begin
          if (!ex_br_taken && ex_is_mc) state <= ST_MC;
          else if (!ex_br_taken && lu_hit && LU_STALL > 1) begin
            lu_cnt <= 2'(LU_STALL - 1);
            state  <= ST_LU;
          end
        end
        ST_LU: begin
          lu_cnt <= lu_cnt - 1'b1;
          if (lu_cnt == 2'd1) state <= ST_RUN;
        end
        ST_MC: if (mc_done) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: two instances (LU_STALL=1 and 2) checked against a bubble-count reference model
module tb_pipe_stall_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_is_mc, ex_br_taken, mc_done;
  logic pc_en[2], ifid_en[2], idex_en[2], ifid_flush[2], idex_flush[2], exmem_flush[2], mc_start[2];
  logic [31:0] sc[2];
  int checks = 0;
  int failures = 0;
  int lu_left[2];
  bit mc_busy[2];
  logic [31:0] cnt[2];
  pipe_stall_ctrl #(.LU_STALL(1), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mc(ex_is_mc),
    .ex_br_taken(ex_br_taken), .mc_done(mc_done), .pc_en(pc_en[0]), .ifid_en(ifid_en[0]),
    .idex_en(idex_en[0]), .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]),
    .exmem_flush(exmem_flush[0]), .mc_start(mc_start[0]), .stall_cnt(sc[0])
  );
  pipe_stall_ctrl #(.LU_STALL(2), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mc(ex_is_mc),
    .ex_br_taken(ex_br_taken), .mc_done(mc_done), .pc_en(pc_en[1]), .ifid_en(ifid_en[1]),
    .idex_en(idex_en[1]), .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]),
    .exmem_flush(exmem_flush[1]), .mc_start(mc_start[1]), .stall_cnt(sc[1])
  );
  function automatic logic hazard();
    return ex_mem_read && ex_rd != 5'd0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction
  // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, mc_start}
  function automatic logic [6:0] expv(int i);
    if (rst) return 7'b0001110;
    if (mc_busy[i]) return mc_done ? 7'b1110000 : 7'b0000010;
    if (lu_left[i] > 0) return 7'b0010100;
    if (ex_br_taken) return 7'b1111100;
    if (ex_is_mc) return 7'b0000011;
    if (hazard()) return 7'b0010100;
    return 7'b1110000;
  endfunction
  function automatic logic [6:0] obs(int i);
    return {pc_en[i], ifid_en[i], idex_en[i], ifid_flush[i], idex_flush[i], exmem_flush[i], mc_start[i]};
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      lu_left[i] = 0;
      mc_busy[i] = 0;
      cnt[i] = '0;
    end
  endtask
  task automatic commit();
    logic [6:0] e[2];
    @(posedge clk);
    for (int i = 0; i < 2; i++) e[i] = expv(i);
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (!e[i][6]) cnt[i] = cnt[i] + 1;
      if (mc_busy[i]) mc_busy[i] = !mc_done;
      else if (lu_left[i] > 0) lu_left[i]--;
      else if (ex_br_taken) ;
      else if (ex_is_mc) mc_busy[i] = 1;
      else if (hazard()) lu_left[i] = i;
    end
  endtask
  task automatic idle();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_mem_read, ex_is_mc, ex_br_taken, mc_done} = '0;
  endtask
  task automatic test_reset();
    model_reset();
    @(negedge clk);
    id_rs1 = 5'd5; id_rs2 = 5'd5; ex_rd = 5'd5;
    {id_use_rs1, id_use_rs2, ex_mem_read, ex_is_mc, ex_br_taken, mc_done} = 6'b111111;
    #2;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== 7'b0001110) begin failures++; $display("FAIL reset_outs dut%0d got=%b want=0001110", i, obs(i)); end
      checks++;
      if (sc[i] !== 32'd0) begin failures++; $display("FAIL reset_cnt dut%0d got=%0d want=0", i, sc[i]); end
    end
    commit();
    @(negedge clk);
    rst = 1'b0;
    idle();
    commit();
  endtask
  task automatic test_load_use();
    logic [31:0] s0, s1;
    s0 = sc[0]; s1 = sc[1];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle();
      if (c == 0) begin ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1; end
      #2;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) begin failures++; $display("FAIL lu_outs c%0d dut%0d got=%b want=%b", c, i, obs(i), expv(i)); end
      end
      if (c == 0) begin
        checks++;
        if ({pc_en[0], idex_flush[0], pc_en[1], idex_flush[1]} !== 4'b0101) begin
          failures++; $display("FAIL lu_first got=%b want=0101", {pc_en[0], idex_flush[0], pc_en[1], idex_flush[1]});
        end
      end
      if (c == 1) begin
        checks++;
        if ({pc_en[0], pc_en[1]} !== 2'b10) begin failures++; $display("FAIL lu_second got=%b want=10", {pc_en[0], pc_en[1]}); end
      end
      commit();
    end
    @(negedge clk);
    checks++;
    if (sc[0] - s0 !== 32'd1) begin failures++; $display("FAIL lu1_cnt got=%0d want=1", sc[0] - s0); end
    checks++;
    if (sc[1] - s1 !== 32'd2) begin failures++; $display("FAIL lu2_cnt got=%0d want=2", sc[1] - s1); end
  endtask
  task automatic test_no_stall();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      ex_mem_read = 1;
      if (c == 0) begin ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1; end
      else begin ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 0; id_rs1 = 5'd3; id_use_rs1 = 1; end
      #2;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== 7'b1110000) begin failures++; $display("FAIL nostall c%0d dut%0d got=%b want=1110000", c, i, obs(i)); end
      end
      commit();
    end
  endtask
  task automatic test_branch();
    logic [31:0] s0;
    s0 = sc[1];
    @(negedge clk);
    idle();
    ex_mem_read = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1; ex_br_taken = 1; ex_is_mc = 1;
    #2;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== 7'b1111100) begin failures++; $display("FAIL branch dut%0d got=%b want=1111100", i, obs(i)); end
    end
    commit();
    @(negedge clk);
    idle();
    #2;
    checks++;
    if (sc[1] !== s0) begin failures++; $display("FAIL branch_cnt got=%0d want=%0d", sc[1], s0); end
    checks++;
    if (obs(1) !== 7'b1110000) begin failures++; $display("FAIL branch_after got=%b want=1110000", obs(1)); end
    commit();
  endtask
  task automatic test_mc();
    logic [31:0] s0;
    int starts = 0;
    int stalls = 0;
    s0 = sc[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle();
      ex_is_mc = (c < 5);
      mc_done = (c == 4);
      ex_br_taken = (c == 2);
      #2;
      starts += int'(mc_start[0]);
      stalls += int'(!pc_en[0] && exmem_flush[0]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) begin failures++; $display("FAIL mc_outs c%0d dut%0d got=%b want=%b", c, i, obs(i), expv(i)); end
      end
      if (c == 4) begin
        checks++;
        if ({pc_en[0], ifid_en[0], idex_en[0], exmem_flush[0]} !== 4'b1110) begin
          failures++; $display("FAIL mc_done got=%b want=1110", {pc_en[0], ifid_en[0], idex_en[0], exmem_flush[0]});
        end
      end
      if (c < 5) commit();
    end
    checks++;
    if (starts !== 1) begin failures++; $display("FAIL mc_start_pulses got=%0d want=1", starts); end
    checks++;
    if (stalls !== 4) begin failures++; $display("FAIL mc_stall_cycles got=%0d want=4", stalls); end
    checks++;
    if (sc[0] - s0 !== 32'd4) begin failures++; $display("FAIL mc_cnt got=%0d want=4", sc[0] - s0); end
    commit();
  endtask
  task automatic test_reset_mid_mc();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      ex_is_mc = 1;
      #2;
      commit();
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== 7'b0001110) begin failures++; $display("FAIL rst_mc_outs dut%0d got=%b want=0001110", i, obs(i)); end
      checks++;
      if (sc[i] !== 32'd0) begin failures++; $display("FAIL rst_mc_cnt dut%0d got=%0d want=0", i, sc[i]); end
    end
    commit();
    @(negedge clk);
    rst = 1'b0;
    idle();
    mc_done = 1;
    #2;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== 7'b1110000) begin failures++; $display("FAIL stray_done dut%0d got=%b want=1110000", i, obs(i)); end
    end
    commit();
    @(negedge clk);
    idle();
    #2;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sc[i] !== 32'd0 || obs(i) !== 7'b1110000) begin
        failures++; $display("FAIL after_rst dut%0d cnt=%0d outs=%b want cnt=0 outs=1110000", i, sc[i], obs(i));
      end
    end
    commit();
  endtask
  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_is_mc = ($urandom_range(0, 7) == 0);
      ex_br_taken = ($urandom_range(0, 7) == 0);
      mc_done = ($urandom_range(0, 3) == 0);
      #2;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) begin failures++; $display("FAIL rand_outs c%0d dut%0d got=%b want=%b", c, i, obs(i), expv(i)); end
        checks++;
        if (sc[i] !== cnt[i]) begin failures++; $display("FAIL rand_cnt c%0d dut%0d got=%0d want=%0d", c, i, sc[i], cnt[i]); end
      end
      commit();
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mc();
    test_reset_mid_mc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
